// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: time-shares one registered serial output bit among four
// requesters. Round-robin arbitration, a per-grant burst limit and a fixed
// one-cycle GAP after every grant before the next arbitration in IDLE.
//
// Handshake: a requester holds req_in[i] high for as long as it has bits to
// send; in every cycle that gnt_out[i] is high and req_in[i] is high, d_in[i]
// is consumed and appears on q_out one cycle later with valid_out high.
// Dropping req_in[i] while granted ends the grant early. q_out is meaningful
// only when valid_out is high.
module mux_rr_scheduler #(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       en_in,
  input  logic [3:0] req_in,
  input  logic [3:0] d_in,
  output logic [1:0] sel_out,
  output logic [3:0] gnt_out,
  output logic       q_out,
  output logic       valid_out,
  output logic       busy_out,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

  state_t           state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       gnt_nxt;
  logic             q_nxt, valid_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] count_inc;
  logic [1:0]       winner;
  logic             found;

  assign count_inc = count + 1'b1;

  // Rotating priority search: first requester at or after ptr wins.
  always_comb begin
    logic [1:0] idx;
    idx    = ptr;
    winner = ptr;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_in[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State register and all registered outputs; reset aborts any burst.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      sel_out   <= 2'd0;
      gnt_out   <= 4'b0000;
      q_out     <= 1'b0;
      valid_out <= 1'b0;
      ptr       <= 2'd0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      sel_out   <= sel_nxt;
      gnt_out   <= gnt_nxt;
      q_out     <= q_nxt;
      valid_out <= valid_nxt;
      ptr       <= ptr_nxt;
      count     <= count_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_out;
    gnt_nxt   = gnt_out;
    q_nxt     = q_out;
    valid_nxt = 1'b0;
    ptr_nxt   = ptr;
    count_nxt = count;
    case (state)
      IDLE: begin
        gnt_nxt = 4'b0000;
        if (en_in && found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          gnt_nxt   = 4'b0001 << winner;
          count_nxt = '0;
        end
      end
      GRANT: begin
        if (req_in[sel_out]) begin
          q_nxt     = d_in[sel_out];
          valid_nxt = 1'b1;
          count_nxt = count_inc;
        end
        // Leave on burst exhaustion or when the owner stops requesting;
        // the pointer always moves past the owner so nobody starves.
        if (!req_in[sel_out] || count_inc == BURST_LAST) begin
          state_nxt = GAP;
          gnt_nxt   = 4'b0000;
          ptr_nxt   = sel_out + 2'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  assign busy_out  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Testbench for mux_rr_scheduler: cycle-level reference model, expected-data
// queue for transferred bits, and directed scenarios with explicit checks.
module tb_mux_rr_scheduler;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       en_in = 1'b0;
  logic [3:0] req_in = 4'b0000;
  logic [3:0] d_in = 4'b0000;
  logic [1:0] sel_out;
  logic [3:0] gnt_out;
  logic       q_out, valid_out, busy_out;
  logic [1:0] dbg_state;

  mux_rr_scheduler #(.BURST_MAX(8), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .req_in(req_in),
    .d_in(d_in), .sel_out(sel_out), .gnt_out(gnt_out), .q_out(q_out),
    .valid_out(valid_out), .busy_out(busy_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- counters, scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];
  int starts[$];
  logic [3:0] prev_gnt = 4'b0000;
  int sel1_valid = 0;

  // reference model: 0 idle, 1 grant, 2 gap
  int         m_state = 0;
  int         m_sel = 0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [3:0] m_gnt = 4'b0000;
  logic       m_q = 1'b0;
  logic       m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    m_gnt = 4'b0000; m_q = 1'b0; m_valid = 1'b0;
    exp_q.delete();
    prev_gnt = 4'b0000;
  endtask

  task automatic model_step(input logic en, input logic [3:0] req, input logic [3:0] d);
    int k, idx;
    bit done;
    case (m_state)
      0: begin
        m_valid = 1'b0;
        done = 0;
        if (en) begin
          for (k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!done && req[idx]) begin
              done = 1; m_sel = idx;
            end
          end
        end
        if (done) begin
          m_state = 1; m_gnt = 4'b0000; m_gnt[m_sel] = 1'b1; m_cnt = 0;
        end
      end
      1: begin
        if (req[m_sel]) begin
          m_q = d[m_sel]; m_valid = 1'b1; m_cnt++;
        end else begin
          m_valid = 1'b0;
        end
        if (!req[m_sel] || m_cnt == 8) begin
          m_state = 2; m_gnt = 4'b0000; m_ptr = (m_sel + 1) % 4;
        end
      end
      default: begin
        m_valid = 1'b0; m_state = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [0:0] e;
    check("gnt", gnt_out, m_gnt);
    check("sel", sel_out, m_sel[1:0]);
    check("valid", valid_out, m_valid);
    check("busy", busy_out, (m_state != 0));
    check("q", q_out, m_q);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("q_data", q_out, e);
      end
    end
    if (valid_out && sel_out == 2'd1) sel1_valid++;
    if (prev_gnt == 4'b0000 && gnt_out != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (gnt_out[i]) starts.push_back(i);
    end
    prev_gnt = gnt_out;
  endtask

  // ---------------- driver ----------------
  task automatic step_cycle(input logic en, input logic [3:0] req, input logic [3:0] d);
    en_in = en; req_in = req; d_in = d;
    if (m_state == 1 && req[m_sel]) exp_q.push_back(d[m_sel]);
    @(posedge clk_in);
    #1;
    model_step(en, req, d);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    en_in = 1'b0; req_in = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;
    logic [3:0] d;
    logic [3:0] req;
    bit dropped;
    int exp_order[5];
    pat = 8'b0100_1101;  // bits sent LSB first: 1,0,1,1,0,0,1,0
    exp_order = '{0, 1, 2, 3, 0};

    // reset then idle
    do_reset();
    #1;
    check("rst_gnt", gnt_out, 4'b0000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_sel", sel_out, 2'd0);
    repeat (20) step_cycle(1'b1, 4'b0000, 4'($urandom_range(0, 15)));

    // single long burst from requester 2, then re-grant
    starts.delete();
    for (int c = 0; c < 14; c++) begin
      d = 4'($urandom_range(0, 15));
      if (m_state == 1) d[2] = pat[m_cnt];
      step_cycle(1'b1, 4'b0100, d);
    end
    check("burst_starts", starts.size(), 2);
    if (starts.size() >= 2) check("burst_regrant", starts[1], 2);
    repeat (10) step_cycle(1'b1, 4'b0000, 4'($urandom_range(0, 15)));

    // round-robin rotation from a fresh pointer
    do_reset();
    starts.delete();
    repeat (60) step_cycle(1'b1, 4'b1111, 4'($urandom_range(0, 15)));
    check("rr_count_ok", starts.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      if (i < starts.size()) check("rr_order", starts[i], exp_order[i]);

    // early release of requester 1 after three transfers
    do_reset();
    starts.delete();
    sel1_valid = 0;
    dropped = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_state == 1 && m_sel == 1 && m_cnt == 3) dropped = 1;
      req = dropped ? 4'b1101 : 4'b0010;
      step_cycle(1'b1, req, 4'($urandom_range(0, 15)));
      if (dropped && c < 19 && m_state == 2 && m_sel == 1) check("early_gnt_off", gnt_out, 4'b0000);
    end
    check("early_valid_bits", sel1_valid, 3);
    check("early_starts_ok", starts.size() >= 2, 1);
    if (starts.size() >= 2) check("early_next", starts[1], 2);
    repeat (12) step_cycle(1'b1, 4'b0000, 4'b0000);

    // enable gating, then asynchronous reset mid-burst
    do_reset();
    repeat (5) step_cycle(1'b0, 4'b1010, 4'($urandom_range(0, 15)));
    check("gate_no_grant", gnt_out, 4'b0000);
    step_cycle(1'b1, 4'b1010, 4'($urandom_range(0, 15)));
    check("gate_grant1", gnt_out, 4'b0010);
    repeat (3) step_cycle(1'b1, 4'b1010, 4'b1111);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_gnt", gnt_out, 4'b0000);
    check("arst_sel", sel_out, 2'd0);
    check("arst_q", q_out, 1'b0);
    check("arst_valid", valid_out, 1'b0);
    check("arst_busy", busy_out, 1'b0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step_cycle(1'b1, 4'b1010, 4'($urandom_range(0, 15)));
    check("post_rst_grant1", gnt_out, 4'b0010);
    repeat (15) step_cycle(1'b1, 4'b1010, 4'($urandom_range(0, 15)));

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Time-shares one serial output bit among four requesters.
- Each cycle, one requester's data bit is routed through a 4:1 select path using a registered select.
- Arbitration is round-robin with a per-grant burst limit and a one-cycle turnaround gap between grants.
- Sits in front of the shared single-bit output channel; drives the select and grant lines and registers the selected bit.

Parameters:
- BURST_MAX, 8: maximum bits transferred per grant. Legal range is 1..15.
- CNT_W, 4: width of the burst counter. Must satisfy 2**CNT_W > BURST_MAX.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- en_in  input  1  when high, permits new grants to be issued.
- req_in  input  4  request line per requester; bit i belongs to requester i.
- d_in  input  4  serial data bit per requester; bit i belongs to requester i.
- sel_out  output  2  index of the currently or most recently granted requester.
- gnt_out  output  4  one-hot grant; all zeros when no grant is active.
- q_out  output  1  registered transferred data bit.
- valid_out  output  1  q_out holds a transferred bit this cycle.
- busy_out  output  1  high in the GRANT and GAP states.

Behaviour:
- Clock and reset: one clock (clk_in); reset (rst_n_in) is asynchronous and active-low.
- Reset values, applied immediately on assertion, including mid-burst:
  - state = IDLE
  - sel_out = 0
  - gnt_out = 4'b0000
  - q_out = 0, valid_out = 0, busy_out = 0
  - priority pointer ptr = 0, count = 0
  - No partial burst resumes after reset release.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en_in = 1 and req_in != 0, choose the winner as the first set bit of req_in, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state = GRANT, sel_out = winner, gnt_out = one-hot(winner), count = 0.
  - Otherwise stay in IDLE with gnt_out = 0.
  - Grant latency is 1 cycle from the sampled request.
- GRANT, each cycle, with s = sel_out:
  - If req_in[s] = 1: transfer. On the next edge q_out <= d_in[s], valid_out <= 1, count <= count+1. If count+1 = BURST_MAX, move to GAP.
  - If req_in[s] = 0: no transfer. valid_out <= 0, q_out holds, move to GAP.
  - On entry to GAP: gnt_out <= 0 and ptr <= (s+1) mod 4. sel_out holds s.
  - Data latency: a bit sampled in a granted cycle appears on q_out, with valid_out high, exactly 1 cycle later.
  - The final bit of a BURST_MAX burst therefore appears during the first GAP cycle.
- GAP:
  - Lasts exactly 1 cycle. valid_out <= 0, then move to IDLE.
  - No arbitration occurs in GAP.
  - Minimum spacing between the last granted cycle of one grant and the first granted cycle of the next is 2 idle-grant cycles (GAP, then IDLE).
- en_in:
  - Gates only the IDLE to GRANT transition.
  - Deasserting en_in during GRANT does not truncate the burst.
- Fairness:
  - ptr always advances past the last winner, including on early termination.
  - Any continuously requesting requester is granted within 3 other grants.
- Transitions in req_in of non-granted requesters have no effect during GRANT or GAP.
- busy_out = 1 in GRANT and GAP, 0 in IDLE, combinationally decoded from state.
- Outside GRANT, q_out retains its last value; consumers qualify q_out with valid_out.

Test Plan:
- Reset then idle: rst_n_in low then high, req_in = 0000 -> gnt_out = 0000, valid_out = 0, busy_out = 0 for 20 cycles.
- Single long burst: en_in = 1, req_in = 0100 held, d_in[2] pattern 1,0,1,1,0,0,1,0, BURST_MAX = 8.
  - gnt_out = 0100 and sel_out = 2 for 8 cycles.
  - q_out reproduces the pattern one cycle later with valid_out high for 8 cycles.
  - Then GAP, IDLE, and a re-grant to requester 2.
- Round-robin rotation: req_in = 1111 held -> grant order 0,1,2,3,0, each grant lasting 8 granted cycles, separated by 2 non-granted cycles.
- Early release: requester 1 granted, req_in[1] dropped after 3 transfers -> exactly 3 valid bits, gnt_out = 0 on the next edge, next grant goes to the next requester at or after index 2.
- Gate and reset mid-burst:
  - en_in = 0 with req_in = 1010 -> no grant.
  - en_in = 1 -> requester 1 granted.
  - Drive rst_n_in low mid-burst, asynchronously -> all outputs 0 immediately.
  - After release with req_in = 1010, requester 1 is granted first (ptr = 0).
